// File: rtl/spcom_pkg.sv
// Shared spcom definitions: the index-width helper and the encoding of the
// binary-to-one-hot pipeline's storage occupancy states.
package spcom_pkg;

  // Storage occupancy of the decoder pipeline (main register M, skid register S).
  typedef enum logic [1:0] {
    BIN2OH_EMPTY = 2'd0,  // M invalid
    BIN2OH_ONE   = 2'd1,  // M valid, S empty
    BIN2OH_TWO   = 2'd2   // M and S both valid
  } bin2oh_state_e;

  // Ceiling log2, used to size a binary index that must address 'value' outputs.
  function automatic int log2_ceil(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/binary_to_onehot_pipe_if.sv
// Handshake bundle of binary_to_onehot_pipe: index input side, one-hot output
// side and the out-of-range error counter controls.
interface binary_to_onehot_pipe_if
  import spcom_pkg::*;
#(
  parameter int DOUT_WIDTH    = 16,
  parameter int DIN_WIDTH     = log2_ceil(DOUT_WIDTH),
  parameter int ERR_CNT_WIDTH = 8
);

  logic                     in_valid;
  logic                     in_ready;
  logic [DIN_WIDTH-1:0]     in_index;
  logic                     out_valid;
  logic                     out_ready;
  logic [DOUT_WIDTH-1:0]    out_onehot;
  logic                     out_err;
  logic                     err_clr;
  logic [ERR_CNT_WIDTH-1:0] err_cnt;

  // Producer of indices / consumer of one-hot words.
  modport master (
    output in_valid, in_index, out_ready, err_clr,
    input  in_ready, out_valid, out_onehot, out_err, err_cnt
  );

  // The decoder itself.
  modport slave (
    input  in_valid, in_index, out_ready, err_clr,
    output in_ready, out_valid, out_onehot, out_err, err_cnt
  );

endinterface

// File: rtl/binary_to_onehot_pipe_decode.sv
// bin2oh_decode: purely combinational binary index -> {one-hot, err}.
// Range checking is compiled in with `define BIN2OH_RANGE_CHECK_EN; without it
// an out-of-range index still decodes to all-zeros but err stays 0.
module bin2oh_decode #(
  parameter int DIN_WIDTH  = 4,
  parameter int DOUT_WIDTH = 16
) (
  input  logic [DIN_WIDTH-1:0]  index,
  output logic [DOUT_WIDTH-1:0] onehot,
  output logic                  err
);

  // Set the bit addressed by index; indices past the top bit leave all zeros.
  always_comb begin
    // NOTE: every output gets a default first so no path through this block can infer a latch.
    onehot = '0;
    err    = 1'b0;
    for (int i = 0; i < DOUT_WIDTH; i++) begin
      onehot[i] = (int'(index) == i);
    end
`ifdef BIN2OH_RANGE_CHECK_EN
    // Only reachable when DOUT_WIDTH is not a power of two.
    err = (int'(index) >= DOUT_WIDTH);
`endif
  end

endmodule

// File: rtl/binary_to_onehot_pipe.sv
// binary_to_onehot_pipe: registered binary-to-one-hot decoder with valid/ready
// on both sides, one cycle of latency and a 2-entry (main + skid) output stage.
// in_ready is a flop, so there is no combinational path from out_ready upstream.
// Optional feature: `define BIN2OH_RANGE_CHECK_EN enables the out-of-range flag
// (out_err) and the saturating err_cnt; otherwise both are tied to zero.
module binary_to_onehot_pipe
  import spcom_pkg::*;
#(
  parameter int DOUT_WIDTH    = 16,
  parameter int DIN_WIDTH     = log2_ceil(DOUT_WIDTH),
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  binary_to_onehot_pipe_if.slave  bus
);

  bin2oh_state_e         state_q, state_d;
  logic                  in_ready_q;

  logic [DOUT_WIDTH-1:0] dec_onehot;
  logic                  dec_err;

  logic [DOUT_WIDTH-1:0] m_onehot_q, s_onehot_q;
  logic                  m_err_q, s_err_q;

  logic                  accept, transfer;
  logic                  load_m_new, load_m_skid, load_s;

  bin2oh_decode #(
    .DIN_WIDTH  (DIN_WIDTH),
    .DOUT_WIDTH (DOUT_WIDTH)
  ) u_decode (
    .index  (bus.in_index),
    .onehot (dec_onehot),
    .err    (dec_err)
  );

  assign accept   = bus.in_valid && in_ready_q;
  assign transfer = (state_q != BIN2OH_EMPTY) && bus.out_ready;

  // Next occupancy and which register loads what this cycle.
  always_comb begin
    state_d     = state_q;
    load_m_new  = 1'b0;
    load_m_skid = 1'b0;
    load_s      = 1'b0;
    case (state_q)
      BIN2OH_EMPTY: begin
        if (accept) begin
          state_d    = BIN2OH_ONE;
          load_m_new = 1'b1;
        end
      end
      BIN2OH_ONE: begin
        if (accept && transfer) begin
          load_m_new = 1'b1;
        end else if (accept) begin
          state_d = BIN2OH_TWO;
          load_s  = 1'b1;
        end else if (transfer) begin
          state_d = BIN2OH_EMPTY;
        end
      end
      BIN2OH_TWO: begin
        // in_ready is low here, so only the drain of M can happen.
        if (transfer) begin
          state_d     = BIN2OH_ONE;
          load_m_skid = 1'b1;
        end
      end
      default: state_d = BIN2OH_EMPTY;
    endcase
  end

  // Occupancy register and the registered ready derived from the next occupancy.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q    <= BIN2OH_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != BIN2OH_TWO);
    end
  end

  // Main (M) and skid (S) data registers; M holds steady while stalled.
  always_ff @(posedge clk) begin
    // NOTE: data registers are reset too, so out_onehot/out_err read as zero straight out of reset.
    if (!rst_n) begin
      m_onehot_q <= '0;
      m_err_q    <= 1'b0;
      s_onehot_q <= '0;
      s_err_q    <= 1'b0;
    end else begin
      if (load_m_new) begin
        m_onehot_q <= dec_onehot;
        m_err_q    <= dec_err;
      end else if (load_m_skid) begin
        m_onehot_q <= s_onehot_q;
        m_err_q    <= s_err_q;
      end
      if (load_s) begin
        s_onehot_q <= dec_onehot;
        s_err_q    <= dec_err;
      end
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = (state_q != BIN2OH_EMPTY);
  assign bus.out_onehot = m_onehot_q;

`ifdef BIN2OH_RANGE_CHECK_EN
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_CNT_MAX = '1;

  logic [ERR_CNT_WIDTH-1:0] err_cnt_q;
  logic                     count_err;

  assign count_err = accept && dec_err;

  // Saturating count of accepted out-of-range indices; a clear that coincides
  // with a new error leaves the count at one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (bus.err_clr) begin
      err_cnt_q <= count_err ? ERR_CNT_WIDTH'(1) : '0;
    end else if (count_err && (err_cnt_q != ERR_CNT_MAX)) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_WIDTH'(1);
    end
  end

  assign bus.out_err = m_err_q;
  assign bus.err_cnt = err_cnt_q;
`else
  // Without range checking the flag path and counter are absent.
  logic unused_err;
  assign unused_err  = m_err_q ^ bus.err_clr;
  assign bus.out_err = 1'b0;
  assign bus.err_cnt = {ERR_CNT_WIDTH{1'b0}};
`endif

endmodule

// File: doc/binary_to_onehot_pipe.md
# binary_to_onehot_pipe

Registered binary-to-one-hot decoder with a valid/ready handshake on both sides. It is the inverse of the one-hot-to-binary encoder in the spcom mux library. It converts a DIN_WIDTH-bit index into a DOUT_WIDTH-bit one-hot vector with one cycle of latency and a 2-entry skid stage, so it can sit directly in select and grant paths between pipelined spcom blocks. Out-of-range indices, possible when DOUT_WIDTH is not a power of two, are flagged and counted.

## Interface
- DOUT_WIDTH, 16: one-hot output width; legal values are ≥2.
- DIN_WIDTH, log2(DOUT_WIDTH) (ceiling): binary index width.
- ERR_CNT_WIDTH, 8: width of the saturating error counter.

- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  index valid.
- in_ready  output  1  block can accept an index; registered.
- in_index  input  DIN_WIDTH  binary index.
- out_valid  output  1  one-hot word valid.
- out_ready  input  1  downstream accepts.
- out_onehot  output  DOUT_WIDTH  decoded vector.
- out_err  output  1  the current output word came from an out-of-range index.
- err_clr  input  1  clears err_cnt.
- err_cnt  output  ERR_CNT_WIDTH  saturating count of out-of-range indices accepted.

## Operation
- Accept condition: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Decode rule: bit in_index is set, for in_index < DOUT_WIDTH. For in_index ≥ DOUT_WIDTH the vector is all-zeros and out_err=1 is carried with that word.
- Storage is a main output register M plus a skid register S. Each holds {onehot, err}.
- FSM states:
  - EMPTY: M invalid.
  - ONE: M valid, S empty.
  - TWO: M and S both valid.
- Transitions:
  - EMPTY + accept → ONE; the decoded word loads into M.
  - ONE + accept + transfer → ONE; M is replaced by the new word.
  - ONE + accept, no transfer → TWO; the new word goes to S.
  - ONE + transfer, no accept → EMPTY.
  - TWO + transfer → ONE; S moves to M. No accept is possible in TWO.
- in_ready = (state != TWO). It is a register output, not a combinational function of out_ready.
- out_valid = (state != EMPTY). out_onehot and out_err come from M and are held stable while out_valid && !out_ready.
- While out_valid=1, out_onehot has exactly one bit set or is all-zeros with out_err=1.
- err_cnt increments by 1 on each accept of an out-of-range index and saturates at 2^ERR_CNT_WIDTH−1.
- err_clr with a simultaneous out-of-range accept gives err_cnt=1; clear and increment both apply. err_clr alone gives 0.
- Reset values: state=EMPTY, in_ready=1, out_valid=0, out_onehot=0, out_err=0, err_cnt=0, S cleared.
- Reset mid-operation discards M and S with no output transfer. in_ready=1 in the cycle after reset is released.

## Timing
- Latency is 1 cycle: an index accepted at edge N is presented on out_* after edge N, when M was empty or transferring at edge N.
- Throughput is 1 word/cycle when out_ready is held high.
- With out_ready=0: two indices are accepted, then in_ready drops in the cycle after the second accept.
- in_ready returns to 1 one cycle after the first transfer out of TWO.
- No combinational path exists from any input to any output.

## Configuration
- BIN2OH_RANGE_CHECK_EN
  - Defined: out-of-range detection, out_err and err_cnt behave as described above.
  - Undefined: out_err is tied 0 and err_cnt is tied 0. An out-of-range index decodes to all-zeros with no flag, and no counter flops are instantiated.
- When DOUT_WIDTH is a power of two, range checking is inert regardless of the macro.

## Structure
- Shared package spcom_pkg holds:
  - the log2 ceiling constant function used for DIN_WIDTH;
  - the state encoding constants BIN2OH_EMPTY=2'd0, BIN2OH_ONE=2'd1, BIN2OH_TWO=2'd2.
- One sub-module, bin2oh_decode: purely combinational index → {onehot, err}, parameterised by DIN_WIDTH and DOUT_WIDTH. The top level holds the FSM, M/S registers and the counter.

## Test plan
- DOUT_WIDTH=16 with out_ready=1: indices 0, 5, 15 on consecutive cycles → outputs 0x0001, 0x0020, 0x8000 on the three following cycles, with out_err=0.
- Backpressure with out_ready=0:
  - accept indices 3 and 7 → in_ready=0, out_onehot=0x0008 held;
  - out_ready pulsed for 1 cycle → out_onehot=0x0080 and in_ready=1 the next cycle.
- DOUT_WIDTH=12 with the macro defined: index 13 → out_onehot=0x000, out_err=1, err_cnt=1. Index 11 → 0x800, out_err=0.
- Saturation with ERR_CNT_WIDTH=2: five out-of-range accepts → err_cnt=3. err_clr together with an out-of-range accept → err_cnt=1.
- Reset in state TWO: rst_n=0 for 1 cycle → out_valid=0, out_onehot=0, in_ready=1, err_cnt=0 after release.
- DOUT_WIDTH=12 with the macro undefined: index 14 → out_onehot=0x000, out_err=0, err_cnt stays 0.
